// File: rtl/led_pattern_gen.sv
// led_pattern_gen: CH_NUM-channel LED driver (off / on / blink / PWM) with one shared prescaler and PWM timebase.
// Optional feature macro LED_BREATHE_EN: PWM mode ramps its level between 0 and the stored duty.
module led_pattern_gen #(
  parameter int CH_NUM      = 4,
  parameter int CNT_NUM     = 25000,
  parameter int DUTY_W      = 8,
  parameter int BLINK_TICKS = 500
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [3:0]        cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [DUTY_W-1:0] cfg_duty,
  output logic              cfg_err,
  output logic [CH_NUM-1:0] led_out
);

  localparam int PW = (CNT_NUM > 1) ? $clog2(CNT_NUM) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CNT_NUM - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_e;

  logic                          rdy_q;
  logic                          err_q, err_d;
  logic [PW-1:0]                 presc_q, presc_d;
  logic [DUTY_W-1:0]             pwm_q, pwm_d;
  logic [CH_NUM-1:0][1:0]        mode_q, mode_d;
  logic [CH_NUM-1:0][DUTY_W-1:0] duty_q, duty_d;
  logic [CH_NUM-1:0][BW-1:0]     bcnt_q, bcnt_d;
  logic [CH_NUM-1:0]             bstate_q, bstate_d;
  logic [CH_NUM-1:0]             led_q, led_d;
  logic [CH_NUM-1:0][DUTY_W-1:0] cmp_lvl;
  logic [CH_NUM-1:0]             wr_hit;
  logic                          tick;
  logic                          wr_acc;
  logic                          ch_ok;

  assign tick   = (presc_q == PRESC_LAST);
  assign wr_acc = cfg_valid & rdy_q;
  assign ch_ok  = ({1'b0, cfg_ch} < 5'(CH_NUM));

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      wr_hit[i] = wr_acc & ch_ok & (cfg_ch == 4'(i));
    end
  end

  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    pwm_d    = tick ? pwm_q + 1'b1 : pwm_q;
    err_d    = wr_acc & ~ch_ok;
    mode_d   = mode_q;
    duty_d   = duty_q;
    bcnt_d   = bcnt_q;
    bstate_d = bstate_q;
    led_d    = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      // A write restarts the blink phase high, overriding a same-cycle tick.
      if (wr_hit[i]) begin
        mode_d[i]   = cfg_mode;
        duty_d[i]   = cfg_duty;
        bcnt_d[i]   = '0;
        bstate_d[i] = 1'b1;
      end else if (tick) begin
        if (bcnt_q[i] == BLINK_LAST) begin
          bcnt_d[i]   = '0;
          bstate_d[i] = ~bstate_q[i];
        end else begin
          bcnt_d[i] = bcnt_q[i] + 1'b1;
        end
      end
      case (mode_e'(mode_q[i]))
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = bstate_q[i];
        MODE_PWM:   led_d[i] = (pwm_q < cmp_lvl[i]);
        default:    led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      presc_q  <= '0;
      pwm_q    <= '0;
      mode_q   <= '0;
      duty_q   <= '0;
      bcnt_q   <= '0;
      bstate_q <= '0;
      led_q    <= '0;
    end else begin
      rdy_q    <= 1'b1;
      err_q    <= err_d;
      presc_q  <= presc_d;
      pwm_q    <= pwm_d;
      mode_q   <= mode_d;
      duty_q   <= duty_d;
      bcnt_q   <= bcnt_d;
      bstate_q <= bstate_d;
      led_q    <= led_d;
    end
  end

`ifdef LED_BREATHE_EN
  localparam logic [DUTY_W-1:0] PWM_LAST = '1;

  logic [CH_NUM-1:0][DUTY_W-1:0] lvl_q, lvl_d;
  logic [CH_NUM-1:0]             down_q, down_d;
  logic                          pwm_wrap;

  assign pwm_wrap = tick & (pwm_q == PWM_LAST);

  // Triangle ramp: one step per PWM period, turning around at 0 and at the stored duty.
  always_comb begin
    lvl_d  = lvl_q;
    down_d = down_q;
    for (int i = 0; i < CH_NUM; i++) begin
      if (wr_hit[i]) begin
        lvl_d[i]  = '0;
        down_d[i] = 1'b0;
      end else if (pwm_wrap) begin
        if (duty_q[i] == '0) begin
          lvl_d[i]  = '0;
          down_d[i] = 1'b0;
        end else if (!down_q[i]) begin
          if (lvl_q[i] >= duty_q[i]) begin
            lvl_d[i]  = lvl_q[i] - 1'b1;
            down_d[i] = 1'b1;
          end else begin
            lvl_d[i] = lvl_q[i] + 1'b1;
          end
        end else begin
          if (lvl_q[i] == '0) begin
            lvl_d[i]  = lvl_q[i] + 1'b1;
            down_d[i] = 1'b0;
          end else begin
            lvl_d[i] = lvl_q[i] - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      lvl_q  <= '0;
      down_q <= '0;
    end else begin
      lvl_q  <= lvl_d;
      down_q <= down_d;
    end
  end

  assign cmp_lvl = lvl_q;
`else
  assign cmp_lvl = duty_q;
`endif

  assign cfg_ready = rdy_q;
  assign cfg_err   = err_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: time-based behavioural model checked every cycle, plus directed literal expectations.
module tb_led_pattern_gen;
  localparam int CH  = 4;
  localparam int CNT = 10;
  localparam int DW  = 4;
  localparam int BT  = 3;
  localparam int PER = CNT * (1 << DW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [3:0]    cfg_ch = 4'd0;
  logic [1:0]    cfg_mode = 2'd0;
  logic [DW-1:0] cfg_duty = '0;
  logic          cfg_err;
  logic [CH-1:0] led_out;

  int checks = 0;
  int failures = 0;

  led_pattern_gen #(
    .CH_NUM(CH), .CNT_NUM(CNT), .DUTY_W(DW), .BLINK_TICKS(BT)
  ) dut (
    .clk_in(clk), .rst_in(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .cfg_err(cfg_err), .led_out(led_out)
  );

  always #5 clk = ~clk;

  // Model state: m = clock edges since the last reset edge; each channel remembers the edge of its last write.
  int      m = 0;
  bit      mdl_on = 1'b0;
  int      mmode[CH];
  int      mduty[CH];
  int      wrm[CH];
  logic    exp_rdy = 1'b0;
  logic    exp_err = 1'b0;
  logic [CH-1:0] exp_led = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

`ifdef LED_BREATHE_EN
  function automatic int bre_lvl(int ch);
    int d, w, pos;
    d = mduty[ch];
    if (d == 0) return 0;
    w = m / PER - wrm[ch] / PER;
    pos = w % (2 * d);
    return (pos <= d) ? pos : 2 * d - pos;
  endfunction
`endif

  function automatic logic mdl_led(int ch);
    int ticks, pwm, cmp;
    ticks = m / CNT;
    pwm = ticks % (1 << DW);
    case (mmode[ch])
      0: return 1'b0;
      1: return 1'b1;
      2: return ((((ticks - wrm[ch] / CNT) / BT) % 2) == 0);
      default: begin
`ifdef LED_BREATHE_EN
        cmp = bre_lvl(ch);
`else
        cmp = mduty[ch];
`endif
        return (pwm < cmp);
      end
    endcase
  endfunction

  always @(posedge clk) begin
    logic acc;
    int idx;
    if (rst) begin
      m = 0;
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      exp_led = '0;
      mdl_on = 1'b1;
      for (int i = 0; i < CH; i++) begin
        mmode[i] = 0;
        mduty[i] = 0;
        wrm[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) exp_led[i] = mdl_led(i);
      idx = int'(cfg_ch);
      acc = cfg_valid && exp_rdy;
      exp_err = acc && (idx >= CH);
      m = m + 1;
      if (acc && idx < CH) begin
        mmode[idx] = int'(cfg_mode);
        mduty[idx] = int'(cfg_duty);
        wrm[idx] = m;
      end
      exp_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      check("led_model", 32'(led_out), 32'(exp_led));
      check("err_model", 32'(cfg_err), 32'(exp_err));
      check("ready_model", 32'(cfg_ready), 32'(exp_rdy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int mode, input int duty);
    cfg_valid = 1'b1;
    cfg_ch = 4'(ch);
    cfg_mode = 2'(mode);
    cfg_duty = DW'(duty);
    step();
    cfg_valid = 1'b0;
  endtask

  // Stops one edge before an edge where (m+1) is a multiple of modulus.
  task automatic align(input int modulus, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 2 * modulus + 2; c++) begin
      if (m % modulus == modulus - 1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  int runs[4];
  logic run_first;

  task automatic sample_runs(input int ch, input int nruns, output bit ok);
    int idx, len;
    logic cur;
    ok = 1'b0;
    idx = 0;
    len = 0;
    cur = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (c == 0) begin
        cur = led_out[ch];
        run_first = cur;
        len = 1;
      end else if (led_out[ch] === cur) begin
        len++;
      end else begin
        runs[idx] = len;
        idx++;
        if (idx == nruns) begin
          ok = 1'b1;
          break;
        end
        cur = led_out[ch];
        len = 1;
      end
    end
  endtask

  task automatic count_high(input int ch, input int n, output int hi);
    hi = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (led_out[ch] === 1'b1) hi++;
    end
  endtask

  initial begin
    bit ok;
    int hi;
    int exp_win[8];

    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_led", 32'(led_out), 32'h0);
      check("rst_ready", 32'(cfg_ready), 32'h0);
    end
    rst = 1'b0;
    step();
    check("ready_after_release", 32'(cfg_ready), 32'h1);

    cfg_write(2, 1, 0);
    check("ch2_on_before_latency", 32'(led_out), 32'h0);
    step();
    check("ch2_on", 32'(led_out), 32'h4);
    cfg_write(2, 0, 0);
    check("ch2_off_before_latency", 32'(led_out), 32'h4);
    step();
    check("ch2_off", 32'(led_out), 32'h0);

    align(CNT, ok);
    check("align_blink", 32'(ok), 32'h1);
    cfg_write(0, 2, 0);
    check("blink_start_latency", 32'(led_out[0]), 32'h0);
    sample_runs(0, 3, ok);
    check("blink_runs_done", 32'(ok), 32'h1);
    check("blink_first_high", 32'(run_first), 32'h1);
    check("blink_high1", runs[0], 30);
    check("blink_low1", runs[1], 30);
    check("blink_high2", runs[2], 30);

    align(CNT, ok);
    check("align_rewrite", 32'(ok), 32'h1);
    cfg_write(0, 2, 0);
    check("rewrite_still_low", 32'(led_out[0]), 32'h0);
    sample_runs(0, 1, ok);
    check("rewrite_run_done", 32'(ok), 32'h1);
    check("rewrite_high_next", 32'(run_first), 32'h1);
    check("rewrite_high_len", runs[0], 30);
    cfg_write(0, 0, 0);

    cfg_write(1, 3, 4);
    step();
    count_high(1, PER, hi);
    check("pwm_duty4", hi, 40);
    cfg_write(1, 3, 0);
    step();
    count_high(1, PER, hi);
    check("pwm_duty0", hi, 0);
    cfg_write(1, 3, 15);
    step();
    count_high(1, PER, hi);
    check("pwm_duty15_low", PER - hi, 10);

    cfg_write(1, 1, 0);
    step();
    check("static_pattern", 32'(led_out), 32'h2);
    cfg_write(5, 1, 7);
    check("err_ch5", 32'(cfg_err), 32'h1);
    check("err_ch5_led", 32'(led_out), 32'h2);
    step();
    check("err_ch5_once", 32'(cfg_err), 32'h0);
    check("err_ch5_led_after", 32'(led_out), 32'h2);
    cfg_valid = 1'b1;
    cfg_ch = 4'd4;
    cfg_mode = 2'd1;
    step();
    check("err_ch4", 32'(cfg_err), 32'h1);
    cfg_ch = 4'd15;
    step();
    check("err_ch15_b2b", 32'(cfg_err), 32'h1);
    cfg_valid = 1'b0;
    step();
    check("err_b2b_clear", 32'(cfg_err), 32'h0);
    check("err_b2b_led", 32'(led_out), 32'h2);

    cfg_valid = 1'b1;
    cfg_ch = 4'd3;
    cfg_mode = 2'd1;
    step();
    cfg_mode = 2'd0;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    check("last_write_wins", 32'(led_out), 32'h2);

    rst = 1'b1;
    cfg_valid = 1'b1;
    cfg_ch = 4'd2;
    cfg_mode = 2'd1;
    step();
    check("rst_mid_led", 32'(led_out), 32'h0);
    check("rst_mid_ready", 32'(cfg_ready), 32'h0);
    rst = 1'b0;
    cfg_valid = 1'b0;
    step();
    check("rst_mid_ready_back", 32'(cfg_ready), 32'h1);
    step();
    step();
    check("rst_with_write_off", 32'(led_out), 32'h0);

    align(PER, ok);
    check("align_pwm_period", 32'(ok), 32'h1);
    cfg_write(3, 3, 3);
`ifdef LED_BREATHE_EN
    exp_win = '{0, 10, 20, 30, 20, 10, 0, 10};
    for (int w = 0; w < 8; w++) begin
      count_high(3, PER, hi);
      check($sformatf("breathe_win%0d", w), hi, exp_win[w]);
    end
`else
    exp_win = '{30, 30, 0, 0, 0, 0, 0, 0};
    for (int w = 0; w < 2; w++) begin
      count_high(3, PER, hi);
      check($sformatf("static_pwm3_win%0d", w), hi, exp_win[w]);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
